// File: rtl/dac_serial_tx.sv
// Frames 16-bit DAC command words MSB-first onto a SYNC/SCLK/DIN serial DAC link.
// Optional build macro DAC_SERIAL_TX_FIFO_EN replaces the one-word holding register with a FIFO.
//
// state   | meaning
// ST_IDLE | link idle, pops the next buffered word and drops dac_sync
// ST_HI   | dac_clk high half of a bit
// ST_LO   | dac_clk low half of a bit (DAC samples on the falling edge)
// ST_END  | dac_clk high tail before dac_sync is released
// ST_GAP  | minimum dac_sync-high time between frames
module dac_serial_tx #(
    parameter int CLK_DIV    = 2,
    parameter int SYNC_GAP   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        dac_sync,
    output logic        dac_clk,
    output logic        dac_din
);
    typedef enum logic [2:0] {ST_IDLE, ST_HI, ST_LO, ST_END, ST_GAP} state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD = 8'(SYNC_GAP - 1);

    state_t      state, state_nxt;
    logic [7:0]  timer, timer_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [14:0] shreg, shreg_nxt;
    logic        sync_nxt, dclk_nxt, din_nxt, done_nxt;
    logic        tc, push, pop;
    logic        buf_nonempty, buf_nonempty_nxt;
    logic [15:0] buf_head;

    assign tc   = (timer == 8'd0);
    assign push = s_valid & s_ready;
    assign pop  = (state == ST_IDLE) & buf_nonempty;

`ifdef DAC_SERIAL_TX_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CNT_ONE;
        else if (pop && !push)
            count_nxt = count - CNT_ONE;
    end

    assign buf_nonempty     = (count != '0);
    assign buf_nonempty_nxt = (count_nxt != '0);
    assign buf_head         = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            s_ready <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            count   <= count_nxt;
            s_ready <= (count_nxt < DEPTH_C);
        end
    end
`else
    logic        hold_valid, hold_valid_nxt;
    logic [15:0] hold_data;

    assign hold_valid_nxt   = push | (hold_valid & ~pop);
    assign buf_nonempty     = hold_valid;
    assign buf_nonempty_nxt = hold_valid_nxt;
    assign buf_head         = hold_data;

    // Ready also while idle so a word can be accepted in the same cycle the held one is popped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            s_ready    <= 1'b1;
        end else begin
            hold_valid <= hold_valid_nxt;
            if (push)
                hold_data <= s_data;
            s_ready <= ~hold_valid_nxt | (state_nxt == ST_IDLE);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            dac_sync   <= 1'b1;
            dac_clk    <= 1'b1;
            dac_din    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            dac_sync   <= sync_nxt;
            dac_clk    <= dclk_nxt;
            dac_din    <= din_nxt;
            frame_done <= done_nxt;
            busy       <= (state_nxt != ST_IDLE) | buf_nonempty_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = tc ? timer : timer - 8'd1;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        case (state)
            ST_IDLE: begin
                if (buf_nonempty) begin
                    state_nxt   = ST_HI;
                    timer_nxt   = DIV_LOAD;
                    bit_cnt_nxt = 4'd0;
                    shreg_nxt   = buf_head[14:0];
                end
            end
            ST_HI: begin
                if (tc) begin
                    state_nxt = ST_LO;
                    timer_nxt = DIV_LOAD;
                end
            end
            ST_LO: begin
                if (tc) begin
                    timer_nxt = DIV_LOAD;
                    if (bit_cnt == 4'd15) begin
                        state_nxt = ST_END;
                    end else begin
                        state_nxt   = ST_HI;
                        shreg_nxt   = {shreg[13:0], 1'b0};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end
                end
            end
            ST_END: begin
                if (tc) begin
                    state_nxt = ST_GAP;
                    timer_nxt = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (tc)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // dac_din only moves with a rising dac_clk or at frame start, never on a falling edge.
    always_comb begin
        sync_nxt = dac_sync;
        dclk_nxt = dac_clk;
        din_nxt  = dac_din;
        done_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (buf_nonempty) begin
                    sync_nxt = 1'b0;
                    din_nxt  = buf_head[15];
                end
            end
            ST_HI: begin
                if (tc)
                    dclk_nxt = 1'b0;
            end
            ST_LO: begin
                if (tc) begin
                    dclk_nxt = 1'b1;
                    if (bit_cnt != 4'd15)
                        din_nxt = shreg[14];
                end
            end
            ST_END: begin
                if (tc) begin
                    sync_nxt = 1'b1;
                    done_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dac_serial_tx.sv
// Bench for dac_serial_tx: cycle-level waveform model plus a pin-level frame decoder.
module tb_dac_serial_tx;
    localparam int C     = 2;
    localparam int G     = 4;
    localparam int DEPTH = 4;
`ifdef DAC_SERIAL_TX_FIFO_EN
    localparam int CAP        = DEPTH;
    localparam int SIM_READY  = 1;
`else
    localparam int CAP        = 1;
    localparam int SIM_READY  = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready, busy, frame_done, dac_sync, dac_clk, dac_din;

    dac_serial_tx #(.CLK_DIV(C), .SYNC_GAP(G), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .busy(busy), .frame_done(frame_done),
        .dac_sync(dac_sync), .dac_clk(dac_clk), .dac_din(dac_din)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Model: a word queue plus the number of cycles elapsed since the current frame started.
    logic [15:0] mq[$];
    int          phase = -1;
    logic [15:0] cur_word = '0;
    logic        last_din = 1'b0;
    bit          m_idle, m_acc;

    function automatic bit model_ready(input bit idle);
        return (mq.size() < CAP) || (CAP == 1 && idle);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            phase    = -1;
            last_din = 1'b0;
        end else begin
            m_idle = (phase < 0);
            m_acc  = s_valid && model_ready(m_idle);
            if (phase >= 0) begin
                phase++;
                if (phase == 33*C + G) begin
                    phase    = -1;
                    last_din = cur_word[0];
                end
            end else if (mq.size() > 0) begin
                cur_word = mq.pop_front();
                phase    = 0;
            end
            if (m_acc)
                mq.push_back(s_data);
        end
    end

    function automatic logic exp_sync();
        return !(phase >= 0 && phase < 33*C);
    endfunction

    function automatic logic exp_clk();
        if (phase >= 0 && phase < 32*C)
            return (phase % (2*C)) < C;
        return 1'b1;
    endfunction

    function automatic logic exp_din();
        int b;
        if (phase < 0)
            return last_din;
        b = phase / (2*C);
        if (b > 15)
            b = 15;
        return cur_word[15-b];
    endfunction

    always @(negedge clk) begin
        check("m_sync",  dac_sync,   exp_sync());
        check("m_clk",   dac_clk,    exp_clk());
        check("m_din",   dac_din,    exp_din());
        check("m_done",  frame_done, (phase == 33*C));
        check("m_busy",  busy,       (phase >= 0) || (mq.size() > 0));
        check("m_ready", s_ready,    model_ready(phase < 0));
    end

    // Pin-level decoder: shifts in dac_din on each dac_clk fall inside a frame.
    int          cyc = 0;
    int          rx_falls = 0;
    int          done_cnt = 0;
    logic [15:0] rx_sh = '0;
    logic [15:0] rx_words[$];
    int          rx_nfall[$];
    int          rx_low[$];
    int          fall_cyc[$];

    always @(posedge clk) cyc++;
    always @(negedge clk) if (frame_done) done_cnt++;

    always @(negedge dac_sync) begin
        if (reset_n) begin
            rx_falls = 0;
            rx_sh    = '0;
            fall_cyc.push_back(cyc);
        end
    end

    always @(negedge dac_clk) begin
        if (reset_n && !dac_sync) begin
            rx_sh = {rx_sh[14:0], dac_din};
            rx_falls++;
        end
    end

    always @(posedge dac_sync) begin
        if (reset_n) begin
            rx_words.push_back(rx_sh);
            rx_nfall.push_back(rx_falls);
            rx_low.push_back(cyc - fall_cyc[$]);
        end
    end

    task automatic push(input logic [15:0] w);
        int n;
        n = 0;
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("push_wait", (n < 5000), 1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int k;
        k = 0;
        while (rx_words.size() < n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("frame_count", rx_words.size(), n);
        k = 0;
        while (busy && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("idle_after", busy, 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, f0, d0, k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_sync",  dac_sync, 1);
        check("rst_clk",   dac_clk,  1);
        check("rst_din",   dac_din,  0);
        check("rst_ready", s_ready,  1);
        check("rst_busy",  busy,     0);
        repeat (100) @(negedge clk);

        base = rx_words.size();
        d0   = done_cnt;
        push(16'hA5C3);
        wait_frames(base + 1);
        check("single_word",  rx_words[base], 16'hA5C3);
        check("single_falls", rx_nfall[base], 16);
        check("single_low",   rx_low[base],   66);
        check("single_done",  done_cnt - d0,  1);
        check("single_din_hold", dac_din, 1);

        base = rx_words.size();
        f0   = fall_cyc.size();
        push(16'h0001);
        push(16'h8000);
        push(16'hFFFF);
        wait_frames(base + 3);
        check("b2b_word0", rx_words[base],     16'h0001);
        check("b2b_word1", rx_words[base + 1], 16'h8000);
        check("b2b_word2", rx_words[base + 2], 16'hFFFF);
        check("b2b_period0", fall_cyc[f0 + 1] - fall_cyc[f0],     71);
        check("b2b_period1", fall_cyc[f0 + 2] - fall_cyc[f0 + 1], 71);
        check("b2b_low2",    rx_low[base + 2], 66);

        base = rx_words.size();
        push(16'h1111);
        push(16'h2222);
        check("simul_ready", s_ready,  SIM_READY);
        check("simul_sync",  dac_sync, 0);
        check("simul_busy",  busy,     1);
        wait_frames(base + 2);
        check("simul_word0", rx_words[base],     16'h1111);
        check("simul_word1", rx_words[base + 1], 16'h2222);

`ifdef DAC_SERIAL_TX_FIFO_EN
        base = rx_words.size();
        for (int i = 0; i < 6; i++) begin
            push(16'h0C00 + 16'(i));
            if (i == 3) check("bp_ready_after4", s_ready, 1);
            if (i == 4) check("bp_ready_after5", s_ready, 0);
        end
        wait_frames(base + 6);
        for (int i = 0; i < 6; i++)
            check("bp_order", rx_words[base + i], 16'h0C00 + 16'(i));
`endif

        base = rx_words.size();
        push(16'h5A5A);
        k = 0;
        while (dac_sync && k < 1000) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (rx_falls < 7 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("mid_reached_7", (rx_falls >= 7), 1);
        #3 reset_n = 1'b0;
        #1;
        check("mid_sync", dac_sync, 1);
        check("mid_clk",  dac_clk,  1);
        check("mid_busy", busy,     0);
        check("mid_ready", s_ready, 1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push(16'h1234);
        wait_frames(base + 1);
        check("mid_discard", rx_words.size(), base + 1);
        check("mid_word",    rx_words[base], 16'h1234);
        check("mid_falls",   rx_nfall[base], 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
